serial_mag_compare: RTL and testbench

Bit-serial magnitude comparator that extends the 2-bit digit compare to operands of arbitrary even width. Operand pairs arrive two bits at a time, most-significant digit first, over a valid/ready stream. Each digit pair goes through a 2-bit gate-level compare cell, and the first differing digit locks the decision. The final equal/less/greater verdict leaves on a registered valid/ready result port, followed by the index of the deciding digit.

---
 rtl/cmp_pkg.sv | 16 +
 rtl/digit_cmp2.sv | 38 +++
 rtl/serial_mag_compare.sv | 130 +++++++++++++
 tb/tb_serial_mag_compare.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and result codes for the serial magnitude comparator
// Purpose: FSM state encoding and the EQ/LT/GT result codes used by the
//          comparator and its scoreboard.
// Ports:   none (package)
package cmp_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  localparam logic [1:0] EQ = 2'd0;
  localparam logic [1:0] LT = 2'd1;
  localparam logic [1:0] GT = 2'd2;

endpackage

// File: rtl/digit_cmp2.sv
// rtl/digit_cmp2.sv - gate-level 2-bit magnitude compare cell
// Purpose: combinational compare of one 2-bit digit pair.
// Ports:   a, b  in  2-bit digits
//          eq    out a == b
//          lt    out a <  b
//          gt    out a >  b
module digit_cmp2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  logic na1, na0, nb1, nb0;
  logic e1, e0;
  logic g_hi, g_lo, l_hi, l_lo;

  not u_na1 (na1, a[1]);
  not u_na0 (na0, a[0]);
  not u_nb1 (nb1, b[1]);
  not u_nb0 (nb0, b[0]);

  xnor u_e1 (e1, a[1], b[1]);
  xnor u_e0 (e0, a[0], b[0]);

  // The low bit only decides when the high bits match.
  and u_g_hi (g_hi, a[1], nb1);
  and u_g_lo (g_lo, e1, a[0], nb0);
  or  u_gt   (gt, g_hi, g_lo);

  and u_l_hi (l_hi, na1, b[1]);
  and u_l_lo (l_lo, e1, na0, b[0]);
  or  u_lt   (lt, l_hi, l_lo);

  and u_eq (eq, e1, e0);

endmodule

// File: rtl/serial_mag_compare.sv
// rtl/serial_mag_compare.sv - bit-serial magnitude comparator, MSB digit first
// Purpose: compares two WIDTH-bit operands delivered two bits per accepted
//          beat; the first differing digit locks the verdict, which is
//          presented on a registered valid/ready result port.
// Ports:   clk, rst_n            clock, async active-low reset
//          clear                 synchronous flush, highest priority
//          in_valid/in_ready     digit handshake, in_a/in_b 2-bit digits
//          out_valid/out_ready   result handshake
//          out_eq/out_lt/out_gt  verdict, exactly one set while out_valid
//          out_pos               index of deciding digit (0 = MSB), 0 if equal
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_a,
  input  logic [1:0]      in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_eq,
  output logic            out_lt,
  output logic            out_gt,
  output logic [IDXW-1:0] out_pos
);

  localparam int              DIGITS = WIDTH / 2;
  localparam logic [IDXW-1:0] LAST   = IDXW'(DIGITS - 1);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            decided;
  logic            lt_l, gt_l;
  logic [IDXW-1:0] pos_l;

  logic            cell_eq, cell_lt, cell_gt;
  logic            accept;
  logic            dec_now, lt_n, gt_n;
  logic [IDXW-1:0] pos_n;

  digit_cmp2 u_cell (
    .a  (in_a),
    .b  (in_b),
    .eq (cell_eq),
    .lt (cell_lt),
    .gt (cell_gt)
  );

  assign in_ready = (state == COLLECT) && !clear;
  assign accept   = in_valid && in_ready;

  // Decision state including the digit on the inputs; once decided, the
  // latched verdict wins and later digits have no effect.
  assign dec_now = decided | ~cell_eq;
  assign lt_n    = decided ? lt_l : cell_lt;
  assign gt_n    = decided ? gt_l : cell_gt;
  assign pos_n   = (!decided && !cell_eq) ? idx : pos_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      decided   <= 1'b0;
      lt_l      <= 1'b0;
      gt_l      <= 1'b0;
      pos_l     <= '0;
      out_valid <= 1'b0;
      out_eq    <= 1'b0;
      out_lt    <= 1'b0;
      out_gt    <= 1'b0;
      out_pos   <= '0;
    end else if (clear) begin
      state     <= COLLECT;
      idx       <= '0;
      decided   <= 1'b0;
      lt_l      <= 1'b0;
      gt_l      <= 1'b0;
      pos_l     <= '0;
      out_valid <= 1'b0;
      out_eq    <= 1'b0;
      out_lt    <= 1'b0;
      out_gt    <= 1'b0;
      out_pos   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (idx == LAST) begin
              state     <= RESULT;
              out_valid <= 1'b1;
              out_eq    <= ~dec_now;
              out_lt    <= lt_n;
              out_gt    <= gt_n;
              out_pos   <= pos_n;
              // Latches start fresh for the next operand.
              idx       <= '0;
              decided   <= 1'b0;
              lt_l      <= 1'b0;
              gt_l      <= 1'b0;
              pos_l     <= '0;
            end else begin
              idx       <= idx + 1'b1;
              decided   <= dec_now;
              lt_l      <= lt_n;
              gt_l      <= gt_n;
              pos_l     <= pos_n;
            end
          end
        end
        RESULT: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            out_gt    <= 1'b0;
            out_pos   <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// tb/tb_serial_mag_compare.sv - scoreboard bench for serial_mag_compare
module tb_serial_mag_compare;
  import cmp_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;
  localparam int IDXW   = 2;

  typedef struct packed {
    logic [1:0]      code;
    logic [IDXW-1:0] pos;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_a = '0;
  logic [1:0]      in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_eq, out_lt, out_gt;
  logic [IDXW-1:0] out_pos;

  int   total = 0;
  int   passed = 0;
  int   rdy_mode = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t bp_e;

  serial_mag_compare #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eq    (out_eq),
    .out_lt    (out_lt),
    .out_gt    (out_gt),
    .out_pos   (out_pos)
  );

  always #5 clk = ~clk;

  // Reference: plain integer compare; deciding digit from the top set bit of a^b.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] x;
    int msb;
    x = a ^ b;
    msb = -1;
    e.pos = '0;
    if (a == b)     e.code = EQ;
    else if (a < b) e.code = LT;
    else            e.code = GT;
    for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
    if (msb >= 0) e.pos = IDXW'((WIDTH - 1 - msb) / 2);
    return e;
  endfunction

  function automatic logic [4:0] exp_bits(input exp_t e);
    return {e.code == EQ, e.code == LT, e.code == GT, e.pos};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Consumer readiness: 0 = held low, 1 = held high, 2 = random per cycle.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every result handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", {27'd0, out_eq, out_lt, out_gt, out_pos}, {27'd0, exp_bits(mon_e)});
      end
    end
  end

  task automatic drive_digit(input logic [1:0] da, input logic [1:0] db);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = da;
    in_b = db;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("digit_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int gap, input bit rnd_gap);
    int g;
    sb.push_back(model(a, b));
    for (int d = 0; d < DIGITS; d++) begin
      drive_digit(a[WIDTH-1-2*d -: 2], b[WIDTH-1-2*d -: 2]);
      if (d < DIGITS - 1) begin
        g = rnd_gap ? $urandom_range(0, gap) : gap;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int n;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {27'd0, out_valid, out_eq, out_lt, out_gt, out_pos}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    idle(2);

    // Greater, decided at digit 2; result one cycle after the last digit
    send(8'hB4, 8'hB1, 0, 0);
    check("gt_latency", {31'd0, out_valid}, 32'd1);
    idle(1);
    check("gt_in_ready_after_take", {31'd0, in_ready}, 32'd1);

    // Less at MSB, equal operands
    send(8'h3F, 8'h40, 0, 0);
    send(8'h5A, 8'h5A, 0, 0);
    send(8'h00, 8'h00, 0, 0);
    send(8'hFF, 8'hFF, 0, 0);

    // Gapped input
    send(8'hC0, 8'h80, 1, 0);
    check("gapped_latency", {31'd0, out_valid}, 32'd1);
    idle(2);

    // Back-pressure: result held for 5 cycles
    rdy_mode = 0;
    idle(2);
    bp_e = model(8'h9C, 8'h9E);
    send(8'h9C, 8'h9E, 0, 0);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold", {27'd0, out_eq, out_lt, out_gt, out_pos}, {27'd0, exp_bits(bp_e)});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rdy_mode = 1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    send(8'h47, 8'h4B, 0, 0);

    // Clear after two digits drops the partial operand
    idle(2);
    drive_digit(2'd0, 2'd0);
    drive_digit(2'd1, 2'd3);
    in_valid = 1'b1;
    in_a = 2'd3;
    in_b = 2'd0;
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    idle(3);
    check("clear_no_result", {31'd0, out_valid}, 32'd0);
    send(8'h21, 8'h21, 0, 0);
    send(8'h12, 8'h13, 0, 0);

    // Randomized traffic with random gaps and back-pressure
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      send(ra, rb, 2, 1);
    end

    // Drain
    rdy_mode = 1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);

    // Reset while a result is pending
    rdy_mode = 0;
    idle(2);
    send(8'h77, 8'h70, 0, 0);
    wait_valid();
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset_mid_result", {27'd0, out_valid, out_eq, out_lt, out_gt, out_pos}, 32'd0);
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_release_in_ready", {31'd0, in_ready}, 32'd1);
    rdy_mode = 1;
    idle(1);
    send(8'hE1, 8'hE9, 0, 0);
    idle(3);
    check("final_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
